// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM slave: parametrised width, depth and wait states, with a
// two-cycle ERROR response for out-of-range, misaligned and oversize beats.
module ahb3lite_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [1:0]            dbg_state_o
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam int LOWW = OFFW + IDXW;

    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);
    localparam logic [2:0]          MAX_SIZE  = 3'(OFFW);
    localparam logic [3:0]          WS        = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;
    logic [LOWW-1:0] addr_q, addr_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic            accept;
    logic            range_err, size_err, align_err, req_err;
    logic [6:0]      align_mask;
    logic [IDXW-1:0] widx;
    logic [OFFW-1:0] woff;
    logic [NB-1:0]   be;
    logic            mem_we;
    logic            unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign accept     = HSEL && HREADY && HTRANS[1];
    assign range_err  = {1'b0, HADDR} >= MEM_BYTES;
    assign size_err   = HSIZE > MAX_SIZE;
    assign align_mask = 7'((8'd1 << HSIZE) - 8'd1);
    assign align_err  = |(HADDR[6:0] & align_mask);
    assign req_err    = range_err || size_err || align_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // HREADYOUT is high here: any pending beat completes this cycle
                state_d = S_IDLE;
                pend_d  = 1'b0;
                if (accept) begin
                    addr_d  = HADDR[LOWW-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WS != 4'd0) begin
                            state_d = S_WAIT;
                            cnt_d   = WS;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
        end
    end

    assign widx   = addr_q[LOWW-1:OFFW];
    assign woff   = addr_q[OFFW-1:0];
    assign mem_we = (state_q == S_IDLE) && pend_q && write_q;

    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(woff)) && (i < int'(woff) + (1 << size_q));
        end
    end

    // Contents survive reset; pend_q is cleared asynchronously so an
    // abandoned write never reaches the array.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA      = (pend_q && !write_q) ? mem_q[widx] : '0;
    assign HREADYOUT   = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign HRESP       = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: three slaves (32b/0 wait, 32b/3 wait, 64b/0 wait) on a
// shared address bus, each selected by its own HSEL bit.
module tb_ahb3lite_sram_slave;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [63:0] hwdata;

    logic [31:0] rdata_a, rdata_b;
    logic [63:0] rdata_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        resp_a, resp_b, resp_c;
    logic [1:0]  st_a, st_b, st_c;

    int n_vec;
    int n_bad;
    int cur;

    ahb3lite_sram_slave #(.DATA_WIDTH(32), .WAIT_STATES(0)) u_a (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata[31:0]), .HREADY(rdy_a),
        .HRDATA(rdata_a), .HREADYOUT(rdy_a), .HRESP(resp_a), .dbg_state_o(st_a)
    );

    ahb3lite_sram_slave #(.DATA_WIDTH(32), .WAIT_STATES(3)) u_b (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata[31:0]), .HREADY(rdy_b),
        .HRDATA(rdata_b), .HREADYOUT(rdy_b), .HRESP(resp_b), .dbg_state_o(st_b)
    );

    ahb3lite_sram_slave #(.DATA_WIDTH(64), .WAIT_STATES(0)) u_c (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[2]), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata), .HREADY(rdy_c),
        .HRDATA(rdata_c), .HREADYOUT(rdy_c), .HRESP(resp_c), .dbg_state_o(st_c)
    );

    // clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard helpers
    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic get_rdy();
        case (cur)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic get_resp();
        case (cur)
            0:       return resp_a;
            1:       return resp_b;
            default: return resp_c;
        endcase
    endfunction

    function automatic logic [63:0] get_rdata();
        case (cur)
            0:       return {32'd0, rdata_a};
            1:       return {32'd0, rdata_b};
            default: return rdata_c;
        endcase
    endfunction

    // driver tasks
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 3'b000;
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 3'b001 << cur;
        haddr  = a;
        htrans = 2'd2;
        hwrite = w;
        hsize  = sz;
    endtask

    // One isolated transfer; returns first data-cycle HRESP, count of
    // HREADYOUT-low cycles, and HRDATA/HRESP in the completing cycle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [63:0] wd, output logic resp1, output int lows,
                        output logic [63:0] rd, output logic resp_end);
        addr_phase(a, w, sz);
        step();
        hwdata = wd;
        bus_idle();
        resp1 = get_resp();
        lows  = 0;
        for (int i = 0; i < 20 && !get_rdy(); i++) begin
            lows++;
            step();
        end
        rd       = get_rdata();
        resp_end = get_resp();
        step();
    endtask

    logic        r1, re;
    int          lw;
    logic [63:0] rd;

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        cur     = 0;
        hresetn = 1'b1;
        hburst  = 3'd0;
        hprot   = 4'd0;
        hwdata  = '0;
        haddr   = '0;
        hsize   = 3'd2;
        bus_idle();
        #2 hresetn = 1'b0;
        #1;
        check_vec("rst_rdy_a",  64'(rdy_a),  64'd1);
        check_vec("rst_resp_a", 64'(resp_a), 64'd0);
        check_vec("rst_rdata_b", 64'(rdata_b), 64'd0);
        check_vec("rst_rdy_c",  64'(rdy_c),  64'd1);
        step();
        step();
        hresetn = 1'b1;

        // zero-wait back-to-back write then read on u_a
        cur = 0;
        addr_phase(32'h10, 1'b1, 3'd2);
        step();
        check_vec("pipe_wr_rdy", 64'(rdy_a), 64'd1);
        hwdata = 64'hDEADBEEF;
        addr_phase(32'h10, 1'b0, 3'd2);
        step();
        check_vec("pipe_rd_rdy", 64'(rdy_a), 64'd1);
        check_vec("pipe_rd_data", get_rdata(), 64'hDEADBEEF);
        bus_idle();
        step();
        check_vec("pipe_after_rdata", get_rdata(), 64'd0);

        // wait states and byte lanes on u_b
        cur = 1;
        xfer(32'h10, 1'b1, 3'd2, 64'h11223344, r1, lw, rd, re);
        check_vec("ws_wr_lows", 64'(lw), 64'd3);
        check_vec("ws_wr_resp", 64'(r1), 64'd0);
        xfer(32'h13, 1'b1, 3'd0, 64'hAA5A5A5A, r1, lw, rd, re);
        check_vec("ws_byte_lows", 64'(lw), 64'd3);
        xfer(32'h10, 1'b0, 3'd2, 64'd0, r1, lw, rd, re);
        check_vec("ws_rd_lows", 64'(lw), 64'd3);
        check_vec("ws_rd_data", rd, 64'hAA223344);

        // out-of-range write on u_a must not touch word 0
        cur = 0;
        xfer(32'h0, 1'b1, 3'd2, 64'h01234567, r1, lw, rd, re);
        xfer(32'h1000, 1'b1, 3'd2, 64'hFFFFFFFF, r1, lw, rd, re);
        check_vec("oor_err1_resp", 64'(r1), 64'd1);
        check_vec("oor_lows", 64'(lw), 64'd1);
        check_vec("oor_err2_resp", 64'(re), 64'd1);
        xfer(32'h0, 1'b0, 3'd2, 64'd0, r1, lw, rd, re);
        check_vec("oor_word0", rd, 64'h01234567);

        // misaligned halfword read and oversize on 32-bit
        xfer(32'h1, 1'b0, 3'd1, 64'd0, r1, lw, rd, re);
        check_vec("misal_resp1", 64'(r1), 64'd1);
        check_vec("misal_resp2", 64'(re), 64'd1);
        check_vec("misal_rdata", rd, 64'd0);
        xfer(32'h8, 1'b0, 3'd3, 64'd0, r1, lw, rd, re);
        check_vec("oversize_resp1", 64'(r1), 64'd1);
        check_vec("oversize_lows", 64'(lw), 64'd1);

        // aligned halfword on the upper lanes of word 0
        xfer(32'h2, 1'b1, 3'd1, 64'hBEEF1111, r1, lw, rd, re);
        check_vec("half_resp", 64'(r1), 64'd0);
        xfer(32'h0, 1'b0, 3'd2, 64'd0, r1, lw, rd, re);
        check_vec("half_word0", rd, 64'hBEEF4567);

        // doubleword on the 64-bit slave
        cur = 2;
        xfer(32'h8, 1'b1, 3'd3, 64'h0123456789ABCDEF, r1, lw, rd, re);
        check_vec("dw_wr_resp", 64'(r1), 64'd0);
        check_vec("dw_wr_lows", 64'(lw), 64'd0);
        xfer(32'h8, 1'b0, 3'd3, 64'd0, r1, lw, rd, re);
        check_vec("dw_rd_data", rd, 64'h0123456789ABCDEF);

        // idle, busy and unselected traffic on u_a
        cur = 0;
        hsel = 3'b001; htrans = 2'd1; haddr = 32'h1000; hsize = 3'd2;
        step();
        check_vec("busy_rdy", 64'(rdy_a), 64'd1);
        check_vec("busy_resp", 64'(resp_a), 64'd0);
        hsel = 3'b000; htrans = 2'd2; hwrite = 1'b0; haddr = 32'h10;
        step();
        check_vec("unsel_rdy", 64'(rdy_a), 64'd1);
        check_vec("unsel_rdata", 64'(rdata_a), 64'd0);
        hsel = 3'b001; htrans = 2'd0;
        step();
        check_vec("idle_rdata", 64'(rdata_a), 64'd0);
        bus_idle();
        step();

        // reset in the second wait cycle of a write on u_b
        cur = 1;
        addr_phase(32'h10, 1'b1, 3'd2);
        step();
        hwdata = 64'hFFFFFFFF;
        bus_idle();
        step();
        check_vec("rstmid_wait_rdy", 64'(rdy_b), 64'd0);
        hresetn = 1'b0;
        #1;
        check_vec("rstmid_rdy", 64'(rdy_b), 64'd1);
        check_vec("rstmid_resp", 64'(resp_b), 64'd0);
        check_vec("rstmid_state", 64'(st_b), 64'd0);
        step();
        step();
        hresetn = 1'b1;
        xfer(32'h10, 1'b0, 3'd2, 64'd0, r1, lw, rd, re);
        check_vec("rstmid_rd_lows", 64'(lw), 64'd3);
        check_vec("rstmid_word", rd, 64'hAA223344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
# ahb3lite_sram_slave

Parametrised AHB3-Lite SRAM slave that succeeds the fixed 32-bit slave on the bench. It adds configurable data width, depth and wait-state count, and replaces silent failures with proper two-cycle ERROR responses for out-of-range, misaligned and oversize transfers. It attaches to the existing AHB interface and the HREADY = HREADYOUT loopback in the top level, and binds the same protocol property checker.

## Interface

Parameters:
- DATA_WIDTH, 32, bus data width; legal values 32 or 64.
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words; must be a power of two.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; range 0..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  burst type; sampled but ignored, since every beat is decoded independently.
- HPROT  in  4  ignored.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus ready; an address phase is accepted only when it is high.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation

- **Accept condition.** An address phase is accepted when HSEL && HREADY && HTRANS[1] are all true at a clock edge. On acceptance the slave registers HADDR, HWRITE, HSIZE and an error flag.
- **Zero-wait responses.** IDLE, BUSY or unselected transfers get a zero-wait OKAY response.
- **Error flag.** The flag is set for any of:
  - HADDR ≥ MEM_DEPTH·(DATA_WIDTH/8);
  - 2^HSIZE > DATA_WIDTH/8;
  - HADDR not aligned to 2^HSIZE.
- **State machine:** IDLE, WAIT, ERR1, ERR2.
  - **IDLE:** HREADYOUT=1, HRESP=0.
    - On an accept with the error flag set, go to ERR1.
    - Else, with WAIT_STATES>0, load the counter with WAIT_STATES and go to WAIT.
    - Else stay in IDLE; this is the data phase of a zero-wait OKAY transfer.
  - **WAIT:** HREADYOUT=0, HRESP=0. The counter decrements each cycle; when it reaches 1, go to IDLE, which completes the data phase with HREADYOUT=1.
  - **ERR1:** HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - **ERR2:** HREADYOUT=1, HRESP=1. Goes to ERR1 or WAIT if a new erroneous or OKAY transfer is accepted this cycle; otherwise goes to IDLE.
- **Writes.**
  - Memory is written at the edge that ends an OKAY data phase (HREADYOUT=1 and a write was pending), using HWDATA.
  - Byte lanes are little-endian. Lanes are enabled for bytes [A mod N, A mod N + 2^HSIZE), where N = DATA_WIDTH/8; unselected bytes are unchanged.
  - Erroneous writes never modify memory.
- **Reads.**
  - HRDATA = mem[word index of the registered address] during an OKAY read data phase. Full words are driven; the master extracts its lanes.
  - HRDATA = 0 in every other cycle, including ERROR phases.
  - A read that immediately follows a write to the same word returns the new data with no extra wait.
- **Pipelining.** A new address phase is accepted in the final data-phase cycle of the previous transfer. Back-to-back OKAY transfers with WAIT_STATES=0 sustain one transfer per cycle.
- **Reset.**
  - Asserting HRESETn low forces IDLE, HREADYOUT=1, HRESP=0, HRDATA=0 and counter=0.
  - A transfer in flight is abandoned without writing.
  - Memory contents are not reset.

## Timing

- **OKAY latency.** The data phase lasts 1+WAIT_STATES cycles after the address phase, with HREADYOUT low for exactly WAIT_STATES cycles.
- **ERROR latency.** The response is always 2 cycles (low/1, then high/1) regardless of WAIT_STATES.
- **Response stability.** HRESP=1 is asserted only in ERR1/ERR2. HRESP and HRDATA are stable while HREADYOUT is low.
- **Reset timing.** Outputs take their reset values asynchronously on assertion. The first transfer can be accepted at the first rising edge after deassertion.

## Test plan

- **Zero-wait pipeline.** WAIT_STATES=0, DATA_WIDTH=32. Back-to-back write 0xDEADBEEF to 0x10, then read 0x10 → read data phase HRDATA=0xDEADBEEF; HREADYOUT stays 1 throughout.
- **Wait states and byte lanes.** WAIT_STATES=3. Write byte 0xAA to 0x13 over word 0x11223344 → HREADYOUT low for 3 cycles; a subsequent read of 0x10 returns 0xAA223344.
- **Out-of-range write.** MEM_DEPTH=1024, write to 0x1000 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no memory word changes.
- **Misaligned and oversize.** Halfword access at 0x01, then HSIZE=3 with DATA_WIDTH=32 → each gets a two-cycle ERROR. With DATA_WIDTH=64, HSIZE=3 at 0x08 → OKAY.
- **Idle and busy traffic.** IDLE and BUSY cycles and HSEL=0 between transfers → HREADYOUT=1, HRESP=0, HRDATA=0.
- **Reset mid-transfer.** Assert HRESETn during the second WAIT cycle of a write → outputs return to reset values immediately and the target word is unchanged. The next transfer after release completes normally.
